// File: rtl/plane_tile_sched_if.sv
// plane_tile_sched_if: primitive input, evaluator drive, credit return and tile sideband
// signals of the tile scheduler; slave is the scheduler's view, master the environment's.
interface plane_tile_sched_if;
    logic        prim_valid;
    logic        prim_ready;
    logic [15:0] prim_xmin, prim_xmax, prim_ymin, prim_ymax;
    logic [17:0] prim_dzdx, prim_dzdy, prim_c;
    logic [15:0] pe_x, pe_y;
    logic [17:0] pe_dzdx, pe_dzdy, pe_c;
    logic        credit_ret;
    logic        tile_valid, tile_last;
    logic [15:0] tile_x, tile_y;
    logic        busy;

    modport slave (
        input  prim_valid, prim_xmin, prim_xmax, prim_ymin, prim_ymax,
               prim_dzdx, prim_dzdy, prim_c, credit_ret,
        output prim_ready, pe_x, pe_y, pe_dzdx, pe_dzdy, pe_c,
               tile_valid, tile_x, tile_y, tile_last, busy
    );

    modport master (
        output prim_valid, prim_xmin, prim_xmax, prim_ymin, prim_ymax,
               prim_dzdx, prim_dzdy, prim_c, credit_ret,
        input  prim_ready, pe_x, pe_y, pe_dzdx, pe_dzdy, pe_c,
               tile_valid, tile_x, tile_y, tile_last, busy
    );
endinterface

// File: rtl/plane_tile_sched.sv
// plane_tile_sched: walks a primitive's bounding box in SIZE x SIZE tiles, one credit-gated
// issue per cycle, with a sideband pipe marking which evaluator z outputs are real tiles.
module plane_tile_sched #(
    parameter int SIZE     = 2,
    parameter int PIPE_LAT = 20,
    parameter int Y_SKEW   = 9,
    parameter int CREDITS  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    plane_tile_sched_if.slave io
);
    localparam int            CW   = $clog2(CREDITS + 1);
    localparam logic [15:0]   MASK = ~16'(SIZE - 1);
    localparam logic [16:0]   STEP = 17'(SIZE);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                    state_q, state_d;
    logic [15:0]               xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [15:0]               tx_q, tx_d, ty_q, ty_d;
    logic [17:0]               dzdx_q, dzdx_d, dzdy_q, dzdy_d, c_q, c_d;
    logic [CW-1:0]             cred_q, cred_d;
    logic [15:0]               pe_x_q, pe_y_q, tile_x_q, tile_y_q;
    logic [17:0]               pe_dzdx_q, pe_c_q, pe_dzdy_q;
    logic [Y_SKEW-1:0][17:0]   dzdy_line_q;
    logic [PIPE_LAT-1:0]       sb_v_q, sb_l_q;
    logic [PIPE_LAT-1:0][15:0] sb_x_q, sb_y_q;
    logic                      tile_valid_q, tile_last_q;
    logic [16:0]               nx, ny;
    logic                      row_end, last, issue, ready, accept, degen;

    // 17-bit steps so a box touching 0xFFFF ends its row instead of wrapping to 0
    always_comb begin
        nx      = {1'b0, tx_q} + STEP;
        ny      = {1'b0, ty_q} + STEP;
        row_end = nx > {1'b0, xmax_q};
        last    = row_end && ny > {1'b0, ymax_q};
        issue   = state_q == SCAN && cred_q != '0;
        ready   = state_q == IDLE || (issue && last);
        accept  = ready && io.prim_valid;
        degen   = io.prim_xmax < io.prim_xmin || io.prim_ymax < io.prim_ymin;
    end

    always_comb
        state_d = accept ? (degen ? IDLE : SCAN) : (issue && last) ? IDLE : state_q;

    always_comb begin
        xmin_d = accept ? io.prim_xmin & MASK : xmin_q;
        xmax_d = accept ? io.prim_xmax : xmax_q;
        ymax_d = accept ? io.prim_ymax : ymax_q;
        dzdx_d = accept ? io.prim_dzdx : dzdx_q;
        dzdy_d = accept ? io.prim_dzdy : dzdy_q;
        c_d    = accept ? io.prim_c : c_q;
        tx_d   = accept ? io.prim_xmin & MASK : issue ? (row_end ? xmin_q : nx[15:0]) : tx_q;
        ty_d   = accept ? io.prim_ymin & MASK : (issue && row_end) ? ny[15:0] : ty_q;
        cred_d = cred_q - CW'(issue) + CW'(io.credit_ret && (issue || cred_q != CMAX));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            dzdx_q       <= '0;
            dzdy_q       <= '0;
            c_q          <= '0;
            cred_q       <= CMAX;
            pe_x_q       <= '0;
            pe_y_q       <= '0;
            pe_dzdx_q    <= '0;
            pe_c_q       <= '0;
            pe_dzdy_q    <= '0;
            dzdy_line_q  <= '0;
            sb_v_q       <= '0;
            sb_l_q       <= '0;
            sb_x_q       <= '0;
            sb_y_q       <= '0;
            tile_valid_q <= 1'b0;
            tile_last_q  <= 1'b0;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymax_q       <= ymax_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            dzdx_q       <= dzdx_d;
            dzdy_q       <= dzdy_d;
            c_q          <= c_d;
            cred_q       <= cred_d;
            if (issue) begin
                pe_x_q    <= tx_q;
                pe_y_q    <= ty_q;
                pe_dzdx_q <= dzdx_q;
                pe_c_q    <= c_q;
            end
            dzdy_line_q  <= {dzdy_line_q[Y_SKEW-2:0], issue ? dzdy_q : dzdy_line_q[0]};
            pe_dzdy_q    <= dzdy_line_q[Y_SKEW-1];
            sb_v_q       <= {sb_v_q[PIPE_LAT-2:0], issue};
            sb_l_q       <= {sb_l_q[PIPE_LAT-2:0], issue && last};
            sb_x_q       <= {sb_x_q[PIPE_LAT-2:0], issue ? tx_q : 16'h0};
            sb_y_q       <= {sb_y_q[PIPE_LAT-2:0], issue ? ty_q : 16'h0};
            tile_valid_q <= sb_v_q[PIPE_LAT-1];
            tile_last_q  <= sb_l_q[PIPE_LAT-1];
            tile_x_q     <= sb_x_q[PIPE_LAT-1];
            tile_y_q     <= sb_y_q[PIPE_LAT-1];
        end
    end

    // returning a credit while the count is already full means the downstream lost track
    credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(io.credit_ret && !issue && cred_q == CMAX));

    assign io.prim_ready = ready;
    assign io.pe_x       = pe_x_q;
    assign io.pe_y       = pe_y_q;
    assign io.pe_dzdx    = pe_dzdx_q;
    assign io.pe_c       = pe_c_q;
    assign io.pe_dzdy    = pe_dzdy_q;
    assign io.tile_valid = tile_valid_q;
    assign io.tile_last  = tile_last_q;
    assign io.tile_x     = tile_x_q;
    assign io.tile_y     = tile_y_q;
    assign io.busy       = state_q == SCAN || (|sb_v_q) || tile_valid_q;
endmodule
